// File: rtl/jtag_host_driver.sv
// ---------------------------------------------------------------------------
// jtag_host_driver
//
// Command-driven JTAG host. Runs one command at a time on a target TAP:
//   TLR_RESET : five TCK cycles with TMS=1, then one with TMS=0, ending in
//               Run-Test/Idle.
//   SHIFT_IR  : Idle -> Shift-IR, shift cmd_len bits, Exit1 -> Update -> Idle.
//   SHIFT_DR  : Idle -> Shift-DR, shift cmd_len bits, Exit1 -> Update -> Idle.
//   reserved  : no pin activity, answers with rsp_data = 0.
// TCK runs only while a command is active: low for CLK_DIV clk cycles, then
// high for CLK_DIV clk cycles. TMS/TDI change only on the clk edge that
// drives TCK low, or at command start while TCK is already low.
//
// Parameters
//   CLK_DIV          clk cycles per TCK half-period (2..255)
//   SHIFT_MAX_WIDTH  maximum bits per shift command
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//   cmd_op, cmd_len, cmd_data   opcode, bit count (0 -> 1, clamped), TDI bits
//   rsp_valid/rsp_ready         response handshake
//   rsp_data                    captured TDO bits, first bit at bit 0
//   tck, tms, tdi               JTAG pins to the target
//   tdo                         JTAG TDO from the target
//
// Build option
//   JTAG_HOST_TDO_SYNC_EN  when defined, tdo passes through a 2-flop
//                          synchronizer and is sampled in the last clk cycle
//                          of the TCK-high phase; requires CLK_DIV >= 3.
// ---------------------------------------------------------------------------
module jtag_host_driver #(
    parameter int CLK_DIV         = 2,
    parameter int SHIFT_MAX_WIDTH = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [1:0]                         cmd_op,
    input  logic [$clog2(SHIFT_MAX_WIDTH):0]   cmd_len,
    input  logic [SHIFT_MAX_WIDTH-1:0]         cmd_data,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [SHIFT_MAX_WIDTH-1:0]         rsp_data,
    output logic                               tck,
    output logic                               tms,
    output logic                               tdi,
    input  logic                               tdo
);

    localparam int LEN_W  = $clog2(SHIFT_MAX_WIDTH) + 1;
    localparam int STEP_W = (LEN_W > 3) ? LEN_W : 3;
    localparam int IDX_W  = (SHIFT_MAX_WIDTH > 1) ? $clog2(SHIFT_MAX_WIDTH) : 1;
    localparam int DIV_W  = 8;

    localparam logic [1:0] OP_TLR = 2'd0;
    localparam logic [1:0] OP_IR  = 2'd1;
    localparam logic [1:0] OP_DR  = 2'd2;

    typedef enum logic [2:0] {IDLE, TLR, NAV, SHIFT, EXIT, RESP} state_t;

    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
        $error("jtag_host_driver: CLK_DIV must be in 2..255");
    end

    state_t                     state_q, state_d;
    logic [1:0]                 op_q, op_sel;
    logic [LEN_W-1:0]           len_q, len_eff, len_sel;
    logic [SHIFT_MAX_WIDTH-1:0] data_q, data_sel, rsp_q;
    logic [STEP_W-1:0]          step_q, step_d;
    logic [DIV_W-1:0]           div_q;
    logic                       tck_q, tms_q, tdi_q, tms_d, tdi_d;
    logic                       accept, active, phase_end, rise, fall;
    logic                       last_step, load_pins, sample_en, tdo_s;

    // Ready only in IDLE and never while reset is held, so it rises in the
    // very first cycle after rst drops.
    assign cmd_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_q;
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;

    assign accept    = cmd_valid && cmd_ready;
    assign active    = (state_q == TLR) || (state_q == NAV) ||
                       (state_q == SHIFT) || (state_q == EXIT);
    assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));
    assign rise      = active && !tck_q && phase_end;
    assign fall      = active && tck_q && phase_end;

    // At command start the pin values must come from the incoming command,
    // because the latched copies are only written on that same edge.
    assign op_sel   = accept ? cmd_op   : op_q;
    assign len_sel  = accept ? len_eff  : len_q;
    assign data_sel = accept ? cmd_data : data_q;

`ifdef JTAG_HOST_TDO_SYNC_EN
    if (CLK_DIV < 3) begin : g_bad_sync_div
        $error("jtag_host_driver: JTAG_HOST_TDO_SYNC_EN requires CLK_DIV >= 3");
    end

    logic [1:0] tdo_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tdo_sync_q <= 2'b00;
        else     tdo_sync_q <= {tdo_sync_q[0], tdo};
    end

    // Late in the high phase the synchronized copy has long settled.
    assign tdo_s     = tdo_sync_q[1];
    assign sample_en = fall && (state_q == SHIFT);
`else
    assign tdo_s     = tdo;
    assign sample_en = rise && (state_q == SHIFT);
`endif

    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        len_eff   = cmd_len;
        last_step = 1'b0;
        state_d   = state_q;
        step_d    = step_q;
        load_pins = 1'b0;
        tms_d     = tms_q;
        tdi_d     = tdi_q;

        if (cmd_len == '0)
            len_eff = LEN_W'(1);
        else if (cmd_len > LEN_W'(SHIFT_MAX_WIDTH))
            len_eff = LEN_W'(SHIFT_MAX_WIDTH);

        case (state_q)
            TLR:     last_step = (step_q == STEP_W'(5));
            NAV:     last_step = (step_q == ((op_q == OP_IR) ? STEP_W'(3) : STEP_W'(2)));
            SHIFT:   last_step = (step_q == STEP_W'(len_q - 1'b1));
            EXIT:    last_step = (step_q == STEP_W'(1));
            default: last_step = 1'b0;
        endcase

        case (state_q)
            IDLE: begin
                if (accept) begin
                    step_d    = '0;
                    load_pins = 1'b1;
                    case (cmd_op)
                        OP_TLR:       state_d = TLR;
                        OP_IR, OP_DR: state_d = NAV;
                        default:      state_d = RESP;
                    endcase
                end
            end
            TLR, NAV, SHIFT, EXIT: begin
                if (fall) begin
                    load_pins = 1'b1;
                    if (last_step) begin
                        step_d = '0;
                        case (state_q)
                            NAV:     state_d = SHIFT;
                            SHIFT:   state_d = EXIT;
                            default: state_d = RESP;
                        endcase
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // TMS/TDI for the TCK cycle that begins after this edge.
        case (state_d)
            TLR: begin
                tms_d = (step_d < STEP_W'(5));
                tdi_d = 1'b0;
            end
            NAV: begin
                tms_d = (op_sel == OP_IR) ? (step_d < STEP_W'(2)) : (step_d == '0);
                tdi_d = 1'b0;
            end
            SHIFT: begin
                tms_d = (step_d == STEP_W'(len_sel - 1'b1));
                tdi_d = data_sel[step_d[IDX_W-1:0]];
            end
            EXIT: begin
                tms_d = (step_d == '0);
                tdi_d = 1'b0;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            len_q   <= '0;
            data_q  <= '0;
            rsp_q   <= '0;
            step_q  <= '0;
            div_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            if (load_pins) begin
                tms_q <= tms_d;
                tdi_q <= tdi_d;
            end
            if (accept) begin
                op_q   <= cmd_op;
                len_q  <= len_eff;
                data_q <= cmd_data;
                rsp_q  <= '0;
                div_q  <= '0;
            end else if (active) begin
                if (phase_end) begin
                    div_q <= '0;
                    tck_q <= ~tck_q;
                end else begin
                    div_q <= div_q + 1'b1;
                end
            end
            if (sample_en)
                rsp_q[step_q[IDX_W-1:0]] <= tdo_s;
        end
    end

endmodule

// File: tb/tb_jtag_host_driver.sv
// ---------------------------------------------------------------------------
// tb_jtag_host_driver
//
// Directed bench for jtag_host_driver against a behavioural 16-state TAP with
// a 4-bit IR (capture 0b0101, IDCODE=0x1 selected on reset, anything else is
// BYPASS) and a 32-bit IDCODE register of 0x0000010F. A clk-domain monitor
// checks TCK half-period lengths and that TMS/TDI never move while TCK is
// high; a TCK-domain monitor counts rising edges and logs TMS.
// ---------------------------------------------------------------------------
module tb_jtag_host_driver;

    localparam int DIV   = 3;
    localparam int W     = 64;
    localparam int LIMIT = 2000;

    localparam logic [3:0]  IR_IDCODE  = 4'h1;
    localparam logic [31:0] IDCODE_VAL = 32'h0000010F;

    logic         clk, rst;
    logic         cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]   cmd_op;
    logic [6:0]   cmd_len;
    logic [W-1:0] cmd_data, rsp_data;
    logic         tck, tms, tdi, tdo;

    int n_checks = 0;
    int n_fails  = 0;

    jtag_host_driver #(.CLK_DIV(DIV), .SHIFT_MAX_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- TAP model ----------------
    typedef enum logic [3:0] {
        T_RESET, T_IDLE, T_SEL_DR, T_CAP_DR, T_SH_DR, T_EX1_DR, T_PAU_DR,
        T_EX2_DR, T_UPD_DR, T_SEL_IR, T_CAP_IR, T_SH_IR, T_EX1_IR, T_PAU_IR,
        T_EX2_IR, T_UPD_IR
    } tap_t;

    function automatic tap_t tap_next(tap_t s, logic m);
        case (s)
            T_RESET:  return m ? T_RESET  : T_IDLE;
            T_IDLE:   return m ? T_SEL_DR : T_IDLE;
            T_SEL_DR: return m ? T_SEL_IR : T_CAP_DR;
            T_CAP_DR: return m ? T_EX1_DR : T_SH_DR;
            T_SH_DR:  return m ? T_EX1_DR : T_SH_DR;
            T_EX1_DR: return m ? T_UPD_DR : T_PAU_DR;
            T_PAU_DR: return m ? T_EX2_DR : T_PAU_DR;
            T_EX2_DR: return m ? T_UPD_DR : T_SH_DR;
            T_UPD_DR: return m ? T_SEL_DR : T_IDLE;
            T_SEL_IR: return m ? T_RESET  : T_CAP_IR;
            T_CAP_IR: return m ? T_EX1_IR : T_SH_IR;
            T_SH_IR:  return m ? T_EX1_IR : T_SH_IR;
            T_EX1_IR: return m ? T_UPD_IR : T_PAU_IR;
            T_PAU_IR: return m ? T_EX2_IR : T_PAU_IR;
            T_EX2_IR: return m ? T_UPD_IR : T_SH_IR;
            default:  return m ? T_SEL_DR : T_IDLE;
        endcase
    endfunction

    tap_t        tap_s = T_RESET;
    logic [3:0]  ir    = IR_IDCODE;
    logic [3:0]  ir_sr = 4'h0;
    logic [31:0] dr_sr = 32'h0;
    logic        byp   = 1'b0;
    logic        tdo_m = 1'b0;

    assign tdo = tdo_m;

    always @(posedge tck) begin
        case (tap_s)
            T_RESET:  ir <= IR_IDCODE;
            T_CAP_IR: ir_sr <= 4'b0101;
            T_SH_IR:  ir_sr <= {tdi, ir_sr[3:1]};
            T_UPD_IR: ir <= ir_sr;
            T_CAP_DR: if (ir == IR_IDCODE) dr_sr <= IDCODE_VAL; else byp <= 1'b0;
            T_SH_DR:  if (ir == IR_IDCODE) dr_sr <= {tdi, dr_sr[31:1]}; else byp <= tdi;
            default: ;
        endcase
        tap_s <= tap_next(tap_s, tms);
    end

    always @(negedge tck) begin
        case (tap_s)
            T_SH_IR: tdo_m <= ir_sr[0];
            T_SH_DR: tdo_m <= (ir == IR_IDCODE) ? dr_sr[0] : byp;
            default: tdo_m <= 1'b0;
        endcase
    end

    // ---------------- monitors ----------------
    int          rise_cnt = 0;
    logic [63:0] tms_log  = '0;

    always @(posedge tck) begin
        rise_cnt <= rise_cnt + 1;
        tms_log  <= {tms_log[62:0], tms};
    end

    int   bad_hi = 0, bad_lo = 0, bad_edge = 0;
    int   run_len = 0;
    logic prev_tck = 1'b0, prev_tms = 1'b1, prev_tdi = 1'b0, had_fall = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            had_fall = 1'b0;
            run_len  = 1;
        end else begin
            if (tck !== prev_tck) begin
                if (prev_tck && run_len != DIV) bad_hi = bad_hi + 1;
                if (!prev_tck && had_fall && run_len != DIV) bad_lo = bad_lo + 1;
                if (prev_tck) had_fall = 1'b1;
                run_len = 1;
            end else begin
                run_len = run_len + 1;
            end
            if (tck && ((tms !== prev_tms) || (tdi !== prev_tdi))) bad_edge = bad_edge + 1;
            if (rsp_valid) had_fall = 1'b0;
        end
        prev_tck = tck;
        prev_tms = tms;
        prev_tdi = tdi;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [6:0] len, input logic [W-1:0] data);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = '0;
    endtask

    task automatic get_rsp(input int hold, output logic [W-1:0] data);
        int n = 0;
        while (!rsp_valid && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid_wait", rsp_valid, 1'b1);
        data = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1'b1);
            check("hold_rsp_data", rsp_data, data);
            check("hold_cmd_ready", cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_one_cycle", rsp_valid, 1'b0);
        check("ready_after_rsp", cmd_ready, 1'b1);
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [6:0] len,
                           input logic [W-1:0] data, input logic [W-1:0] exp_data,
                           input int exp_rises, input int hold);
        int base;
        logic [W-1:0] got;
        base = rise_cnt;
        send_cmd(op, len, data);
        get_rsp(hold, got);
        check({tag, "_data"}, got, exp_data);
        check({tag, "_tck_rises"}, 64'(rise_cnt - base), 64'(exp_rises));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_len   = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tck", tck, 1'b0);
        check("rst_tms", tms, 1'b1);
        check("rst_tdi", tdi, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, '0);

        rst = 1'b0;
        #1;
        check("ready_after_rst", cmd_ready, 1'b1);

        // TLR: six cycles, TMS 1,1,1,1,1,0
        run_cmd("tlr", 2'd0, 7'd4, 64'hDEAD, '0, 6, 0);
        check("tlr_tms_seq", 64'(tms_log[5:0]), 64'(6'b111110));

        // IR capture 0101 shifted out while loading IDCODE
        run_cmd("ir_idcode", 2'd1, 7'd4, 64'h1, 64'h5, 10, 0);
        check("ir_tms_seq", 64'(tms_log[9:0]), 64'(10'b1100000110));

        // IDCODE read
        run_cmd("dr_idcode", 2'd2, 7'd32, '0, 64'h0000010F, 37, 0);
        check("tck_high_len", 64'(bad_hi), 64'd0);
        check("tck_low_len", 64'(bad_lo), 64'd0);
        check("pin_change_edge", 64'(bad_edge), 64'd0);

        // len 0 behaves as 1 bit; len above max clamps to 64
        run_cmd("dr_len0", 2'd2, 7'd0, '0, 64'h1, 6, 0);
        run_cmd("dr_clamp", 2'd2, 7'd100, {64{1'b1}}, 64'hFFFFFFFF_0000010F, 69, 0);

        // reserved opcode: no TCK, zero response
        run_cmd("nop", 2'd3, 7'd8, 64'hFF, '0, 0, 0);

        // select BYPASS, then shift through the one-bit register
        run_cmd("ir_bypass", 2'd1, 7'd4, 64'hF, 64'h5, 10, 0);
        run_cmd("dr_bypass", 2'd2, 7'd8, 64'hA5, 64'h4A, 13, 10);

        // reset in the middle of a 32-bit DR shift, at bit 10
        base = rise_cnt;
        send_cmd(2'd2, 7'd32, 64'h12345678);
        n = 0;
        while ((rise_cnt - base) < 14 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_bit10", 64'(rise_cnt - base), 64'd14);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tck", tck, 1'b0);
        check("abort_tms", tms, 1'b1);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready", cmd_ready, 1'b1);
        check("abort_no_rsp", rsp_valid, 1'b0);

        run_cmd("tlr2", 2'd0, 7'd1, '0, '0, 6, 0);
        run_cmd("dr_idcode2", 2'd2, 7'd32, '0, 64'h0000010F, 37, 0);

        check("final_tck_high_len", 64'(bad_hi), 64'd0);
        check("final_tck_low_len", 64'(bad_lo), 64'd0);
        check("final_pin_change_edge", 64'(bad_edge), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/jtag_host_driver.md
JTAG_HOST_DRIVER -- requirements
Module: jtag_host_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, clk cycles per TCK half-period (legal range 2..255).
REQ-002 SHALL have parameter SHIFT_MAX_WIDTH, default 64, maximum bits per shift command.
REQ-003 SHALL have port clk, input, 1, block clock; one clock, all state on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port cmd_valid/cmd_ready, in/out, 1/1, command handshake; transfer when both are high on a rising edge.
REQ-006 SHALL have port cmd_op, input, 2, command code: 0=TLR_RESET, 1=SHIFT_IR, 2=SHIFT_DR, 3=reserved (completes as NOP).
REQ-007 SHALL have port cmd_len, input, $clog2(SHIFT_MAX_WIDTH)+1, bits to shift; 0 is treated as 1, and values above SHIFT_MAX_WIDTH are clamped.
REQ-008 SHALL have port cmd_data, input, SHIFT_MAX_WIDTH, TDI payload, shifted LSB first.
REQ-009 SHALL have port rsp_valid/rsp_ready, out/in, 1/1, response handshake.
REQ-010 SHALL have port rsp_data, output, SHIFT_MAX_WIDTH, captured TDO bits, first captured bit at bit 0, zero above cmd_len.
REQ-011 SHALL have port tck/tms/tdi, output, 1 each, JTAG pins driven to the target TAP.
REQ-012 SHALL have port tdo, input, 1, target TDO.

Function
REQ-013 SHALL generate tck from a half-period counter: low for CLK_DIV clk cycles, then high for CLK_DIV cycles; tck runs only while a command is active and is otherwise held low.
REQ-014 SHALL change tms/tdi only in the clk cycle where tck goes low, or at command start while tck is already low.
REQ-015 SHALL sample tdo in the clk cycle where tck goes high, valid only for TCK cycles in Shift-IR or Shift-DR.
REQ-016 SHALL use FSM states IDLE, TLR, NAV, SHIFT, EXIT, RESP.
REQ-017 SHALL hold cmd_ready=1 only in IDLE; an accepted command latches op, len and data.
REQ-018 TLR: SHALL emit 5 TCK cycles with TMS=1, then 1 cycle with TMS=0, ending in Run-Test/Idle; rsp_data=0.
REQ-019 NAV: SHIFT_IR SHALL emit TMS sequence 1,1,0,0; SHIFT_DR SHALL emit 1,0,0; the TAP enters Shift state with no shift yet.
REQ-020 SHIFT: SHALL emit cmd_len TCK cycles with tdi=data[i], TMS=0 except TMS=1 on the final bit (Shift to Exit1).
REQ-021 EXIT: SHALL emit TMS 1 (Update), then 0 (Run-Test/Idle).
REQ-022 RESP: SHALL assert rsp_valid and hold rsp_data stable until rsp_ready, then return to IDLE; with rsp_ready held high, the handshake takes exactly 1 cycle.
REQ-023 Total TCK cycles per command: TLR=6, IR=len+6, DR=len+5; each cycle is 2*CLK_DIV clk cycles.
REQ-024 SHALL make the first command after reset execute as issued; the host does not auto-reset the TAP.
REQ-025 SHALL ignore cmd_valid outside IDLE, and SHALL ignore rsp_ready when rsp_valid=0.

Reset
REQ-026 SHALL drive outputs on rst: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0; FSM=IDLE, counters=0.
REQ-027 SHALL assert cmd_ready in the first clk cycle after rst deasserts.
REQ-028 SHALL, on rst mid-command, abort immediately with no response; the target TAP state is then undefined until a TLR_RESET is issued.

Configuration
REQ-029 With macro JTAG_HOST_TDO_SYNC_EN defined, tdo SHALL pass through a 2-flop synchronizer and be sampled in the last clk cycle of the tck-high phase; CLK_DIV SHALL be >=3, with an elaboration error if it is less.
REQ-030 Without JTAG_HOST_TDO_SYNC_EN, tdo SHALL be sampled unsynchronized per REQ-015, and CLK_DIV>=2 is allowed.

Verification
REQ-031 After reset, issue TLR_RESET -> exactly 6 tck rising edges with TMS pattern 1,1,1,1,1,0, then rsp_valid with rsp_data=0.
REQ-032 TLR, then SHIFT_IR len=4 data=0x1 against a TAP model with IR capture 0b0101 -> TMS 1,1,0,0,0,0,0,1,1,0; rsp_data=0x5.
REQ-033 With IDCODE selected, SHIFT_DR len=32 data=0 against IDCODE 0x0000010F -> rsp_data=0x0000010F; 37 TCK cycles; tck high/low each CLK_DIV clks.
REQ-034 In BYPASS, SHIFT_DR len=8 data=0xA5 -> rsp_data=0x4A (one-bit delay, first bit 0); hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stay stable, and cmd_ready stays 0.
REQ-035 Assert rst at bit 10 of a 32-bit DR shift -> next cycle tck=0, tms=1, no rsp_valid; a following TLR plus IDCODE read returns 0x0000010F.
REQ-036 Rebuild with JTAG_HOST_TDO_SYNC_EN and CLK_DIV=3; rerun REQ-033 -> same rsp_data; CLK_DIV=2 -> elaboration error.
